mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store front-end that sits directly upstream of DataMemory in the MEM stage. It accepts one load or store request at a time from the EX/MEM side and drives DataMemory's word-wide port. Sub-word loads (lb/lbu/lh/lhu) are aligned and extended here. Sub-word stores (sb/sh) are done as read-modify-write. It flags misaligned or illegal accesses and back-pressures the pipeline while busy.

Parameters:
ADDR_WIDTH, 32, width of req_addr and Mem_address.
ZERO_ON_ERROR, 1, when 1, resp_rdata is forced to 0 on an error response.

Ports:
clk  input  1  single clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset, sampled on posedge clk.
req_valid  input  1  request present.
req_ready  output  1  unit is idle and can accept a request.
req_is_load  input  1  request is a load.
req_is_store  input  1  request is a store.
req_size  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  32  store data; the value is right-justified.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load data; 0 for stores.
resp_error  output  1  qualifies resp_valid: the access was misaligned or illegal.
Mem_read  output  1  DataMemory read enable.
Mem_write  output  1  DataMemory write enable.
Mem_address  output  ADDR_WIDTH  word-aligned byte address, {req_addr[ADDR_WIDTH-1:2],2'b00}.
Write_data  output  32  full word to DataMemory.
Read_Data  input  32  DataMemory read data; combinational from Mem_address while Mem_read=1.

Behaviour:
- DataMemory contract: reads are asynchronous. A write is committed at the posedge where Mem_write=1.
- Byte order is little-endian. The byte lane is addr[1:0]; the half lane is addr[1].
- Request acceptance:
  - A request is accepted at a posedge where req_valid & req_ready.
  - On acceptance, addr, size, unsigned and wdata are latched. Inputs are not re-sampled afterwards.
  - req_valid with neither is_load nor is_store is ignored: not accepted, no response.
- FSM states: IDLE, RD, RMW_RD, RMW_WR, WR, RESP, ERR.
- IDLE: req_ready=1. Transitions on acceptance:
  - is_load & is_store, or size=11, or misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> ERR.
  - load -> RD.
  - word store -> WR.
  - byte or half store -> RMW_RD.
- RD: Mem_read=1. Capture the extended lane of Read_Data -> RESP.
- RMW_RD: Mem_read=1. Capture Read_Data -> RMW_WR.
- RMW_WR: Mem_write=1. Write_data = captured word with the target lane replaced by wdata[7:0] or wdata[15:0] -> RESP.
- WR: Mem_write=1, Write_data=wdata -> RESP.
- RESP: resp_valid=1, resp_error=0 -> IDLE.
- ERR: resp_valid=1, resp_error=1, no memory access -> IDLE.
- Latency from acceptance edge to resp_valid:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - error: 1 cycle.
- req_ready=1 only in IDLE, so there is no overlap. A new request may be accepted in the cycle after RESP/ERR.
- Mem_read and Mem_write are decoded from state and gated by ~reset, so no write commits in a reset cycle.
- In all states other than those above, Mem_read=Mem_write=0 and Write_data=0.
- Reset (any state, including mid-RMW): the next state is IDLE and latched registers clear to 0. After the reset edge: req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, Mem_read=0, Mem_write=0, Mem_address=0, Write_data=0. A partially completed RMW leaves memory unchanged.
- resp_rdata holds its value until the next response; it is meaningful only with resp_valid.

Test Plan:
1. Word store 0xDEADBEEF @0x10, then lw @0x10 -> Mem_write pulses one cycle with Mem_address=0x10; load response resp_rdata=0xDEADBEEF two cycles after acceptance.
2. sb 0x80 @0x13 onto word 0x11223344 -> RMW_RD then RMW_WR; memory word 0x80223344; lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080.
3. sh 0xABCD @0x12 onto 0x00000000 -> word 0xABCD0000; lh @0x12 -> 0xFFFFABCD; lhu -> 0x0000ABCD.
4. lw @0x11, sh @0x13, size=11, is_load&is_store -> each gives resp_valid with resp_error=1 one cycle after acceptance; Mem_read=Mem_write=0 throughout; memory unchanged.
5. Assert reset during RMW_RD of sb @0x20 -> no Mem_write ever asserted; after reset, lw @0x20 returns the original word; all outputs at reset values.
6. Back-to-back req_valid held high for three loads -> req_ready low while busy; each is accepted exactly once; three resp_valid pulses in request order.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front-end placed directly in front of a word-wide DataMemory in
// the MEM stage. It takes one load or store at a time and drives DataMemory's
// word port:
//   - word loads and stores go straight through (one memory cycle each);
//   - byte/half loads pick the addressed lane out of the read word and
//     sign- or zero-extend it;
//   - byte/half stores are a read-modify-write: read the word, splice the new
//     lane in, write the word back;
//   - misaligned or malformed requests are rejected with an error response and
//     never touch memory.
// Byte order is little-endian: byte lane = addr[1:0], half lane = addr[1].
//
// Ports
//   clk           : single clock, all state changes on the rising edge
//   reset         : synchronous, active-high
//   req_valid     : request present
//   req_ready     : unit idle and able to accept (high only in IDLE)
//   req_is_load   : request is a load
//   req_is_store  : request is a store
//   req_size      : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr      : byte address
//   req_wdata     : store data, right-justified
//   resp_valid    : one-cycle completion pulse
//   resp_rdata    : extended load data (0 for stores); held until next response
//   resp_error    : qualifies resp_valid, access was misaligned or illegal
//   Mem_read      : DataMemory read enable
//   Mem_write     : DataMemory write enable (commits on the rising edge)
//   Mem_address   : word-aligned byte address to DataMemory
//   Write_data    : full word written to DataMemory
//   Read_Data     : DataMemory read data, combinational from Mem_address
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter bit ZERO_ON_ERROR = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_load,
  input  logic                  req_is_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,

  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,

  output logic                  Mem_read,
  output logic                  Mem_write,
  output logic [ADDR_WIDTH-1:0] Mem_address,
  output logic [31:0]           Write_data,
  input  logic [31:0]           Read_Data
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    RMW_WR,
    WR,
    RESP,
    ERR
  } state_t;

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_state_next;

  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rmw_word;   // word read during RMW_RD
  logic [31:0]             r_rdata;      // response data register

  // ---------------------------------------------------------------------------
  // Request decode (evaluated on the live inputs, used only at acceptance)
  // ---------------------------------------------------------------------------
  logic w_accept;
  logic w_req_error;
  logic w_misaligned;

  // A request with neither load nor store set is simply not accepted.
  assign w_accept = req_valid & req_ready & (req_is_load | req_is_store);

  assign w_misaligned = ((req_size == SZ_HALF) & req_addr[0]) |
                        ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

  assign w_req_error = (req_is_load & req_is_store) |
                       (req_size == SZ_BAD) |
                       w_misaligned;

  // ---------------------------------------------------------------------------
  // Load lane extraction: selects the addressed lane of the live read word and
  // extends it according to the latched size/unsigned flags.
  // ---------------------------------------------------------------------------
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_load_data;

  assign w_ld_byte = Read_Data[{r_addr[1:0], 3'b000} +: 8];
  assign w_ld_half = Read_Data[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    w_load_data = Read_Data;
    case (r_size)
      SZ_BYTE: w_load_data = {{24{~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: w_load_data = {{16{~r_unsigned & w_ld_half[15]}}, w_ld_half};
      default: w_load_data = Read_Data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store merge: splice the new byte/half into the word captured in RMW_RD.
  // ---------------------------------------------------------------------------
  logic [31:0] w_merged;

  always_comb begin
    w_merged = r_rmw_word;
    if (r_size == SZ_BYTE) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_error) begin
            w_state_next = ERR;
          end else if (req_is_load) begin
            w_state_next = RD;
          end else if (req_size == SZ_WORD) begin
            w_state_next = WR;
          end else begin
            w_state_next = RMW_RD;
          end
        end
      end
      RD:      w_state_next = RESP;
      RMW_RD:  w_state_next = RMW_WR;
      RMW_WR:  w_state_next = RESP;
      WR:      w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'h0;
      r_rmw_word <= 32'h0;
      r_rdata    <= 32'h0;
    end else begin
      r_state <= w_state_next;

      // Request fields are captured once; later input changes are ignored.
      if (w_accept) begin
        r_addr     <= req_addr;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
      end

      // Error response data is decided at acceptance, since ERR follows
      // immediately.
      if (w_accept && w_req_error && ZERO_ON_ERROR) begin
        r_rdata <= 32'h0;
      end

      case (r_state)
        RD:         r_rdata    <= w_load_data;
        RMW_RD:     r_rmw_word <= Read_Data;
        RMW_WR, WR: r_rdata    <= 32'h0;  // stores respond with zero data
        default:    ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP) | (r_state == ERR);
  assign resp_error = (r_state == ERR);
  assign resp_rdata = r_rdata;

  // Enables are gated by reset so a write can never commit on a reset edge,
  // which keeps a half-finished read-modify-write from touching memory.
  assign Mem_read  = ~reset & ((r_state == RD) | (r_state == RMW_RD));
  assign Mem_write = ~reset & ((r_state == RMW_WR) | (r_state == WR));

  assign Mem_address = {r_addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    Write_data = 32'h0;
    case (r_state)
      RMW_WR:  Write_data = w_merged;
      WR:      Write_data = r_wdata;
      default: Write_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Drives mem_access_unit against a behavioural DataMemory (64 words, async
// read, write on the rising edge). A byte-array reference model computes every
// expected response when a request is issued and pushes it to a queue; a
// monitor pops and compares whenever resp_valid is seen, including the cycle
// in which the response is expected to appear.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_is_load;
  logic            req_is_store;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [AW-1:0]   req_addr;
  logic [31:0]     req_wdata;
  logic            resp_valid;
  logic [31:0]     resp_rdata;
  logic            resp_error;
  logic            Mem_read;
  logic            Mem_write;
  logic [AW-1:0]   Mem_address;
  logic [31:0]     Write_data;
  logic [31:0]     Read_Data;

  mem_access_unit #(.ADDR_WIDTH(AW), .ZERO_ON_ERROR(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_load  (req_is_load),
    .req_is_store (req_is_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .Mem_read     (Mem_read),
    .Mem_write    (Mem_write),
    .Mem_address  (Mem_address),
    .Write_data   (Write_data),
    .Read_Data    (Read_Data)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // DataMemory model (environment, not reference)
  // ---------------------------------------------------------------------------
  logic [31:0] dmem [0:63];
  logic        init_we = 1'b0;
  logic [5:0]  init_idx = '0;
  logic [31:0] init_word = '0;
  int          n_writes = 0;
  int          n_reads  = 0;
  logic [31:0] last_waddr = '0;

  assign Read_Data = dmem[Mem_address[7:2]];

  always @(posedge clk) begin
    if (init_we) begin
      dmem[init_idx] <= init_word;
    end else if (Mem_write) begin
      dmem[Mem_address[7:2]] <= Write_data;
      n_writes   <= n_writes + 1;
      last_waddr <= Mem_address;
    end
    if (Mem_read) n_reads <= n_reads + 1;
  end

  // ---------------------------------------------------------------------------
  // Reference model: byte-addressed memory plus the access rules
  // ---------------------------------------------------------------------------
  logic [7:0] ref_mem [0:255];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  task automatic model(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output int lat);
    int nb;
    int a;
    logic [31:0] v;
    nb  = 1 << sz;
    a   = int'(addr[7:0]);
    err = (ld && st) || (sz == 2'b11) || ((a % nb) != 0);
    rd  = 32'h0;
    lat = 1;
    if (!err) begin
      if (ld) begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (!uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rd  = v;
        lat = 2;
      end else begin
        for (int i = 0; i < nb; i++) ref_mem[a + i] = wdata[8 * i +: 8];
        lat = (nb == 4) ? 2 : 3;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  exp_t mon_e;

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_rdata",   resp_rdata,      mon_e.rdata);
        check("resp_error",   32'(resp_error), 32'(mon_e.err));
        check("resp_latency", 32'(cyc),        32'(mon_e.due));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (called right after a negedge)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit keep_valid, input bit track);
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          waited;
    exp_t        e;
    req_valid    = 1'b1;
    req_is_load  = ld;
    req_is_store = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      check("ready_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    if (!ld && !st) begin
      // Neither load nor store: must be ignored and leave the unit idle.
      repeat (2) begin
        @(negedge clk);
        check("ignored_req_ready", 32'(req_ready), 32'h1);
      end
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      model(ld, st, sz, uns, addr, wdata, rd, er, lat);
      e.rdata = rd;
      e.err   = er;
      e.due   = cyc + lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check("busy_after_accept", 32'(req_ready), 32'h0);
    if (!keep_valid) begin
      req_valid    = 1'b0;
      req_is_load  = 1'($urandom);
      req_is_store = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
    end
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (!(req_ready === 1'b1 && exp_q.size() == 0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("idle_timeout", 32'(req_ready === 1'b1 && exp_q.size() == 0), 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),  32'h1);
    check({tag, "_resp_valid"},  32'(resp_valid), 32'h0);
    check({tag, "_resp_error"},  32'(resp_error), 32'h0);
    check({tag, "_resp_rdata"},  resp_rdata,      32'h0);
    check({tag, "_mem_read"},    32'(Mem_read),   32'h0);
    check({tag, "_mem_write"},   32'(Mem_write),  32'h0);
    check({tag, "_mem_address"}, Mem_address,     32'h0);
    check({tag, "_write_data"},  Write_data,      32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int          w0;
  int          r0;
  logic        r_ld;
  logic        r_st;
  logic [1:0]  r_sz;
  logic [31:0] r_ad;
  logic [31:0] exp_word;

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_is_load  = 1'b0;
    req_is_store = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    @(negedge clk);
    init_we = 1'b1;
    for (int w = 0; w < 64; w++) begin
      init_idx  = 6'(w);
      init_word = $urandom;
      for (int i = 0; i < 4; i++) ref_mem[4 * w + i] = init_word[8 * i +: 8];
      @(negedge clk);
    end
    init_we = 1'b0;
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    // 1: word store then word load
    w0 = n_writes;
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_idle();
    check("t1_write_count", 32'(n_writes - w0), 32'h1);
    check("t1_write_addr",  last_waddr,         32'h10);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);

    // 2: byte RMW onto 0x11223344
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAAAA80, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 1'b1);

    // 3: half RMW onto zero
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h5555ABCD, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 1'b1);

    // 4: error cases never touch memory
    wait_idle();
    w0 = n_writes;
    r0 = n_reads;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        1'b0, 1'b1);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h1234FFFF, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b0, 1'b1);
    wait_idle();
    check("t4_no_writes", 32'(n_writes - w0), 32'h0);
    check("t4_no_reads",  32'(n_reads - r0),  32'h0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);

    // 5: reset during RMW_RD abandons the store
    wait_idle();
    w0 = n_writes;
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h000000EE, 1'b0, 1'b0);
    check("t5_in_rmw_read", 32'(Mem_read), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rmw");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_write", 32'(n_writes - w0), 32'h0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);

    // 6: back-to-back loads with req_valid held high
    wait_idle();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 1'b1);

    // Ignored request (neither load nor store)
    wait_idle();
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 19))
        0:       begin r_ld = 1'b0; r_st = 1'b0; end
        1:       begin r_ld = 1'b1; r_st = 1'b1; end
        default: begin r_ld = 1'($urandom); r_st = ~r_ld; end
      endcase
      r_sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_ad = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && r_sz != 2'b11) r_ad = r_ad & ~((32'h1 << r_sz) - 32'h1);
      issue(r_ld, r_st, r_sz, 1'($urandom), r_ad, $urandom, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    check("drain_queue", 32'(exp_q.size()), 32'h0);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 64; w++) begin
      exp_word = {ref_mem[4 * w + 3], ref_mem[4 * w + 2], ref_mem[4 * w + 1], ref_mem[4 * w]};
      check($sformatf("mem_word_%0d", w), dmem[w], exp_word);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
